// File: rtl/parada_rampa_parcial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parada_pkg
// Purpose  : Shared types and constants for the soft-stop ramp controller.
//            State enum, one-hot level codes {100,50,30} and PWM duty
//            percentages, plus a helper that keeps only the highest level.
// Revision : 1.0 - initial release
// ============================================================================
package parada_pkg;

  typedef enum logic [2:0] {
    PASO    = 3'd0,
    BAJA100 = 3'd1,
    BAJA50  = 3'd2,
    BAJA30  = 3'd3,
    PARO    = 3'd4
  } estado_parada_t;

  // Level codes packed as {100%, 50%, 30%}
  localparam logic [2:0] NIVEL_30  = 3'b001;
  localparam logic [2:0] NIVEL_50  = 3'b010;
  localparam logic [2:0] NIVEL_100 = 3'b100;

  localparam int PWM_PCT_30  = 30;
  localparam int PWM_PCT_50  = 50;
  localparam int PWM_PCT_100 = 100;

  // Reduces any combination of upstream levels to one-hot (or zero),
  // highest level winning.
  function automatic logic [2:0] nivel_mayor(input logic [2:0] niveles);
    logic [2:0] res;
    res = 3'b000;
    if (niveles[2])      res = NIVEL_100;
    else if (niveles[1]) res = NIVEL_50;
    else if (niveles[0]) res = NIVEL_30;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parada_rampa_parcial_contador_permanencia.sv
`default_nettype none
// ============================================================================
// Module   : contador_permanencia
// Purpose  : Clear/enable up-counter with terminal-count equality compare.
//            Clear has priority over enable.
// Ports    : clk, reset (async, active-high), clr, en, term[CNT_W]
//            -> cuenta[CNT_W] (current count), fin (cuenta == term)
// Revision : 1.0 - initial release
// ============================================================================
module contador_permanencia
  import parada_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cuenta,
  output logic             fin
);

  logic [CNT_W-1:0] cuenta_q;
  logic [CNT_W-1:0] cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (clr)     cuenta_d = '0;
    else if (en) cuenta_d = cuenta_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cuenta_q <= '0;
    else       cuenta_q <= cuenta_d;
  end

  assign cuenta = cuenta_q;
  assign fin    = (cuenta_q == term);

endmodule
`default_nettype wire

// File: rtl/parada_rampa_parcial.sv
`default_nettype none
// ============================================================================
// Module   : parada_rampa_parcial
// Purpose  : Soft-stop controller. Passes the start-ramp level through
//            (registered, highest level only) and, on a stop request, steps
//            the drive 100% -> 50% -> 30% -> off with a dwell per level.
//            Emergencia forces an immediate stop.
// Ports    : clk, reset (async, active-high), Parar, Emergencia,
//            in_30/in_50/in_100 (upstream levels)
//            -> out_30/out_50/out_100 (drive), detenido (stopped),
//               ocupado (ramp-down in progress)
// Options  : PARADA_PWM_EN adds parameter PWM_PER and output pwm_out, a
//            PWM with duty set by the active level, updated per period.
// Revision : 1.0 - initial release
// ============================================================================
module parada_rampa_parcial
  import parada_pkg::*;
#(
  parameter int DWELL_100 = 1000,
  parameter int DWELL_50  = 1000,
  parameter int DWELL_30  = 1000,
  parameter int CNT_W     = 16
`ifdef PARADA_PWM_EN
  ,
  parameter int PWM_PER   = 100
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic Parar,
  input  logic Emergencia,
  input  logic in_30,
  input  logic in_50,
  input  logic in_100,
  output logic out_30,
  output logic out_50,
  output logic out_100,
  output logic detenido,
`ifdef PARADA_PWM_EN
  output logic pwm_out,
`endif
  output logic ocupado
);

  estado_parada_t   state_q, state_d;
  logic [2:0]       niv_q, niv_d;
  logic             detenido_q, detenido_d;
  logic             ocupado_q, ocupado_d;
  logic [2:0]       entrada;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] dwell_term;
  logic             dwell_fin;
  logic             dwell_clr;
  logic             dwell_en;

  assign entrada = nivel_mayor({in_100, in_50, in_30});

  always_comb begin
    dwell_term = '0;
    case (state_q)
      BAJA100: dwell_term = CNT_W'(DWELL_100 - 1);
      BAJA50:  dwell_term = CNT_W'(DWELL_50 - 1);
      BAJA30:  dwell_term = CNT_W'(DWELL_30 - 1);
      default: dwell_term = '0;
    endcase
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (Emergencia) begin
      state_d = PARO;
    end else begin
      case (state_q)
        PASO: begin
          if (Parar) begin
            if (entrada == NIVEL_100)     state_d = BAJA100;
            else if (entrada == NIVEL_50) state_d = BAJA50;
            else if (entrada == NIVEL_30) state_d = BAJA30;
            else                          state_d = PARO;
          end
        end
        BAJA100: begin
          if (!Parar)         state_d = PASO;
          else if (dwell_fin) state_d = BAJA50;
        end
        BAJA50: begin
          if (!Parar)         state_d = PASO;
          else if (dwell_fin) state_d = BAJA30;
        end
        BAJA30: begin
          if (!Parar)         state_d = PASO;
          else if (dwell_fin) state_d = PARO;
        end
        PARO: begin
          if (!Parar) state_d = PASO;
        end
        default: state_d = PASO;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state itself.
  always_comb begin
    niv_d      = 3'b000;
    detenido_d = 1'b0;
    ocupado_d  = 1'b0;
    case (state_d)
      PASO:    niv_d = entrada;
      BAJA100: begin niv_d = NIVEL_100; ocupado_d = 1'b1; end
      BAJA50:  begin niv_d = NIVEL_50;  ocupado_d = 1'b1; end
      BAJA30:  begin niv_d = NIVEL_30;  ocupado_d = 1'b1; end
      PARO:    detenido_d = 1'b1;
      default: niv_d = 3'b000;
    endcase
  end

  // Any state change restarts the dwell; counting saturates so it can never
  // wrap back onto a terminal value.
  assign dwell_clr = (state_d != state_q);
  assign dwell_en  = ((state_d == BAJA100) || (state_d == BAJA50) ||
                      (state_d == BAJA30)) && (dwell_cnt != {CNT_W{1'b1}});

  contador_permanencia #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clr    (dwell_clr),
    .en     (dwell_en),
    .term   (dwell_term),
    .cuenta (dwell_cnt),
    .fin    (dwell_fin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PASO;
      niv_q      <= 3'b000;
      detenido_q <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      niv_q      <= niv_d;
      detenido_q <= detenido_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign out_100  = niv_q[2];
  assign out_50   = niv_q[1];
  assign out_30   = niv_q[0];
  assign detenido = detenido_q;
  assign ocupado  = ocupado_q;

`ifdef PARADA_PWM_EN
  localparam logic [CNT_W-1:0] DUTY_30  = CNT_W'((PWM_PER * PWM_PCT_30) / 100);
  localparam logic [CNT_W-1:0] DUTY_50  = CNT_W'((PWM_PER * PWM_PCT_50) / 100);
  localparam logic [CNT_W-1:0] DUTY_100 = CNT_W'((PWM_PER * PWM_PCT_100) / 100);

  logic [CNT_W-1:0] per_cnt;
  logic             per_fin;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  contador_permanencia #(
    .CNT_W (CNT_W)
  ) u_periodo (
    .clk    (clk),
    .reset  (reset),
    .clr    (per_fin),
    .en     (1'b1),
    .term   (CNT_W'(PWM_PER - 1)),
    .cuenta (per_cnt),
    .fin    (per_fin)
  );

  // Duty is latched only at the wrap so a level change waits for the next
  // period boundary.
  always_comb begin
    duty_d = duty_q;
    if (per_fin) begin
      case (niv_q)
        NIVEL_100: duty_d = DUTY_100;
        NIVEL_50:  duty_d = DUTY_50;
        NIVEL_30:  duty_d = DUTY_30;
        default:   duty_d = '0;
      endcase
    end
    pwm_d = !Emergencia && (per_cnt < duty_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parada_rampa_parcial.sv
`default_nettype none
// ============================================================================
// Module   : tb_parada_rampa_parcial
// Purpose  : Self-checking bench for parada_rampa_parcial with short dwells
//            (4/3/2). A behavioural model tracks "mode / level / cycles left"
//            and predicts the registered outputs each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parada_rampa_parcial;

  localparam int D100 = 4;
  localparam int D50  = 3;
  localparam int D30  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Parar = 1'b0;
  logic Emergencia = 1'b0;
  logic in_30 = 1'b0;
  logic in_50 = 1'b0;
  logic in_100 = 1'b0;
  logic out_30, out_50, out_100, detenido, ocupado;
`ifdef PARADA_PWM_EN
  logic pwm_out;
`endif

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = passing through, 1 = ramping down, 2 = stopped.
  // m_lvl is the percentage currently driven, m_rem the cycles left at it.
  int m_mode = 0;
  int m_lvl  = 0;
  int m_rem  = 0;

  always #5 clk = ~clk;

  parada_rampa_parcial #(
    .DWELL_100 (D100),
    .DWELL_50  (D50),
    .DWELL_30  (D30),
    .CNT_W     (8)
`ifdef PARADA_PWM_EN
    ,
    .PWM_PER   (10)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Parar      (Parar),
    .Emergencia (Emergencia),
    .in_30      (in_30),
    .in_50      (in_50),
    .in_100     (in_100),
    .out_30     (out_30),
    .out_50     (out_50),
    .out_100    (out_100),
    .detenido   (detenido),
`ifdef PARADA_PWM_EN
    .pwm_out    (pwm_out),
`endif
    .ocupado    (ocupado)
  );

  function automatic int highest();
    if (in_100)     return 100;
    else if (in_50) return 50;
    else if (in_30) return 30;
    return 0;
  endfunction

  function automatic int dwell_of(input int lvl);
    if (lvl == 100) return D100;
    if (lvl == 50)  return D50;
    return D30;
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_lvl == 100, m_lvl == 50, m_lvl == 30, m_mode == 2, m_mode == 1};
  endfunction

  function automatic logic [4:0] obs_vec();
    return {out_100, out_50, out_30, detenido, ocupado};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_lvl  = 0;
    m_rem  = 0;
  endtask

  task automatic model_step();
    if (Emergencia) begin
      m_mode = 2;
      m_lvl  = 0;
    end else if (m_mode == 0) begin
      if (Parar) begin
        m_lvl = highest();
        if (m_lvl == 0) m_mode = 2;
        else begin
          m_mode = 1;
          m_rem  = dwell_of(m_lvl);
        end
      end else begin
        m_lvl = highest();
      end
    end else if (m_mode == 1) begin
      if (!Parar) begin
        m_mode = 0;
        m_lvl  = highest();
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_lvl = (m_lvl == 100) ? 50 : (m_lvl == 50) ? 30 : 0;
          if (m_lvl == 0) m_mode = 2;
          else            m_rem  = dwell_of(m_lvl);
        end
      end
    end else begin
      m_lvl = 0;
      if (!Parar) begin
        m_mode = 0;
        m_lvl  = highest();
      end
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic set_in(input logic a100, input logic a50, input logic a30);
    in_100 = a100;
    in_50  = a50;
    in_30  = a30;
  endtask

  task automatic test_reset();
    set_in(1, 0, 0);
    repeat (3) begin
      tick();
      checks++;
      if (obs_vec() !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold: got %b expected %b", obs_vec(), 5'b00000);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs_vec(), 5'b10000);
    end
  endtask

  task automatic test_ramp_100();
    set_in(1, 0, 0);
    Parar = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ramp100 cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (obs_vec() !== 5'b00010) begin
      errors++;
      $display("FAIL ramp100_end: got %b expected %b", obs_vec(), 5'b00010);
    end
    Parar = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== 5'b10000) begin
      errors++;
      $display("FAIL ramp100_exit: got %b expected %b", obs_vec(), 5'b10000);
    end
  endtask

  task automatic test_ramp_50();
    set_in(0, 1, 0);
    tick();
    Parar = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ramp50 cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    Parar = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    set_in(1, 0, 0);
    tick();
    Parar = 1'b1;
    for (int i = 0; i < D100 + 2; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL abort_pre cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    Parar = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== 5'b10000) begin
      errors++;
      $display("FAIL abort_resume: got %b expected %b", obs_vec(), 5'b10000);
    end
    Parar = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL abort_restart cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    Parar = 1'b0;
    tick();
  endtask

  task automatic test_emergency();
    set_in(1, 0, 0);
    Parar = 1'b1;
    tick();
    tick();
    Emergencia = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_vec() !== 5'b00010) begin
        errors++;
        $display("FAIL emerg_hold cyc%0d: got %b expected %b", i, obs_vec(), 5'b00010);
      end
    end
    Emergencia = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_vec() !== 5'b00010) begin
        errors++;
        $display("FAIL emerg_parar_held cyc%0d: got %b expected %b", i, obs_vec(), 5'b00010);
      end
    end
    Parar = 1'b0;
    tick();
    checks++;
    if (obs_vec() !== 5'b10000) begin
      errors++;
      $display("FAIL emerg_exit: got %b expected %b", obs_vec(), 5'b10000);
    end
  endtask

  task automatic test_priority();
    logic [2:0] pats [4];
    logic [4:0] want [4];
    pats[0] = 3'b101; want[0] = 5'b10000;
    pats[1] = 3'b011; want[1] = 5'b01000;
    pats[2] = 3'b001; want[2] = 5'b00100;
    pats[3] = 3'b000; want[3] = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      set_in(pats[i][2], pats[i][1], pats[i][0]);
      tick();
      checks++;
      if (obs_vec() !== want[i]) begin
        errors++;
        $display("FAIL priority pat%b: got %b expected %b", pats[i], obs_vec(), want[i]);
      end
    end
    Parar = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== 5'b00010) begin
      errors++;
      $display("FAIL stop_from_zero: got %b expected %b", obs_vec(), 5'b00010);
    end
    Parar = 1'b0;
    tick();
  endtask

  task automatic test_reset_midramp();
    set_in(1, 0, 0);
    Parar = 1'b1;
    repeat (D100 + 1) tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== 5'b00000) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", obs_vec(), 5'b00000);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_midramp_after cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    Parar = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [2:0] v;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) Parar = ~Parar;
      Emergencia = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 5) == 0) begin
        v = 3'($urandom_range(0, 7));
        set_in(v[2], v[1], v[0]);
      end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    Parar = 1'b0;
    Emergencia = 1'b0;
    tick();
  endtask

`ifdef PARADA_PWM_EN
  task automatic test_pwm();
    int want [3];
    logic [2:0] pats [3];
    int highs;
    pats[0] = 3'b100; want[0] = 10;
    pats[1] = 3'b010; want[1] = 5;
    pats[2] = 3'b001; want[2] = 3;
    Parar = 1'b0;
    Emergencia = 1'b0;
    for (int p = 0; p < 3; p++) begin
      set_in(pats[p][2], pats[p][1], pats[p][0]);
      repeat (25) tick();
      highs = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (pwm_out === 1'b1) highs++;
      end
      checks++;
      if (highs != want[p]) begin
        errors++;
        $display("FAIL pwm_duty pat%b: got %0d expected %0d", pats[p], highs, want[p]);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    #2;
    test_reset();
    test_ramp_100();
    test_ramp_50();
    test_abort();
    test_emergency();
    test_priority();
    test_reset_midramp();
    test_random();
`ifdef PARADA_PWM_EN
    test_pwm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
